// File: rtl/uart_pkg.sv
// Shared constants for the UART Rx frame parser: SOF marker, FSM encoding, error codes.
package uart_pkg;
   localparam logic [7:0] UART_SOF = 8'hA5;

   typedef enum logic [1:0] {
      ST_HUNT    = 2'd0,
      ST_LEN     = 2'd1,
      ST_PAYLOAD = 2'd2,
      ST_CSUM    = 2'd3
   } state_t;

   localparam logic [1:0] ERR_NONE    = 2'b00;
   localparam logic [1:0] ERR_CSUM    = 2'b01;
   localparam logic [1:0] ERR_LEN     = 2'b10;
   localparam logic [1:0] ERR_TIMEOUT = 2'b11;
endpackage

// File: rtl/uart_parser_timeout.sv
// Inter-byte idle counter; expired_o flags the cycle that completes TIMEOUT_CYCLES idle cycles.
module uart_parser_timeout #(
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic clk_i,
   input  logic arst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic expired_o
);
   localparam int unsigned W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i)     cnt_d = '0;
      else if (en_i) cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i or negedge arst_ni) begin
      if (!arst_ni) cnt_q <= '0;
      else          cnt_q <= cnt_d;
   end

   assign expired_o = en_i && !clr_i && (cnt_q == LIMIT);
endmodule

// File: rtl/uart_rx_frame_parser.sv
// Pops the Rx FIFO and parses SOF/LEN/payload/CSUM frames, streaming payload cut-through.
// Build option: UART_PARSER_TIMEOUT_EN adds an inter-byte timeout (Error_Code 11).
module uart_rx_frame_parser
   import uart_pkg::*;
#(
   parameter int unsigned MAX_LEN        = 64,
   parameter int unsigned TIMEOUT_CYCLES = 50000
) (
   input  logic       CLK,
   input  logic       Areset,
   input  logic       Rx_FIFO_Empty,
   input  logic [7:0] Rx_Data,
   output logic       Read_Enable,
   output logic [7:0] Payload_Data,
   output logic       Payload_Valid,
   input  logic       Payload_Ready,
   output logic       Frame_Done,
   output logic       Frame_Error,
   output logic [1:0] Error_Code
);
   localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

   if (MAX_LEN == 0 || MAX_LEN > 255 || TIMEOUT_CYCLES == 0) begin : g_bad_cfg
      $error("uart_rx_frame_parser: illegal MAX_LEN/TIMEOUT_CYCLES");
   end

   state_t     state_q, state_d;
   logic       re_q, re_d, cap_q;
   logic [7:0] csum_q, csum_d, cnt_q, cnt_d, pdata_q, pdata_d;
   logic       pvld_q, pvld_d, done_q, done_d, err_q, err_d;
   logic [1:0] code_q, code_d;
   logic       stall, tmo;

   // An un-accepted payload byte blocks further pops while in PAYLOAD.
   assign stall = (state_q == ST_PAYLOAD) && pvld_q && !Payload_Ready;

`ifdef UART_PARSER_TIMEOUT_EN
   logic idle_clr, idle_en;
   assign idle_clr = cap_q || (state_q == ST_HUNT);
   assign idle_en  = (state_q != ST_HUNT) && !re_q && !cap_q && !stall && Rx_FIFO_Empty;

   uart_parser_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
      .clk_i     (CLK),
      .arst_ni   (Areset),
      .clr_i     (idle_clr),
      .en_i      (idle_en),
      .expired_o (tmo)
   );
`else
   assign tmo = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      csum_d  = csum_q;
      cnt_d   = cnt_q;
      pdata_d = pdata_q;
      pvld_d  = pvld_q && !Payload_Ready;
      done_d  = 1'b0;
      err_d   = 1'b0;
      code_d  = code_q;
      re_d    = !re_q && !cap_q && !Rx_FIFO_Empty && !stall && !tmo;

      if (tmo) begin
         err_d   = 1'b1;
         code_d  = ERR_TIMEOUT;
         state_d = ST_HUNT;
      end else if (cap_q) begin
         unique case (state_q)
            ST_HUNT: if (Rx_Data == UART_SOF) state_d = ST_LEN;
            ST_LEN: begin
               if (Rx_Data > MAX_LEN_B) begin
                  err_d   = 1'b1;
                  code_d  = ERR_LEN;
                  state_d = ST_HUNT;
               end else if (Rx_Data == 8'h00) begin
                  csum_d  = 8'h00;
                  state_d = ST_CSUM;
               end else begin
                  csum_d  = Rx_Data;
                  cnt_d   = Rx_Data;
                  state_d = ST_PAYLOAD;
               end
            end
            ST_PAYLOAD: begin
               pdata_d = Rx_Data;
               pvld_d  = 1'b1;
               csum_d  = csum_q ^ Rx_Data;
               cnt_d   = cnt_q - 8'd1;
               if (cnt_q == 8'd1) state_d = ST_CSUM;
            end
            ST_CSUM: begin
               if (Rx_Data == csum_q) begin
                  done_d = 1'b1;
                  code_d = ERR_NONE;
               end else begin
                  err_d  = 1'b1;
                  code_d = ERR_CSUM;
               end
               state_d = ST_HUNT;
            end
            default: state_d = ST_HUNT;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge Areset) begin
      if (!Areset) begin
         state_q <= ST_HUNT;
         re_q    <= 1'b0;
         cap_q   <= 1'b0;
         csum_q  <= 8'h00;
         cnt_q   <= 8'h00;
         pdata_q <= 8'h00;
         pvld_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
      end else begin
         state_q <= state_d;
         re_q    <= re_d;
         cap_q   <= re_q;
         csum_q  <= csum_d;
         cnt_q   <= cnt_d;
         pdata_q <= pdata_d;
         pvld_q  <= pvld_d;
         done_q  <= done_d;
         err_q   <= err_d;
         code_q  <= code_d;
      end
   end

   assign Read_Enable   = re_q;
   assign Payload_Data  = pdata_q;
   assign Payload_Valid = pvld_q;
   assign Frame_Done    = done_q;
   assign Frame_Error   = err_q;
   assign Error_Code    = code_q;
endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Scoreboard bench: a frame-level reference model queues expected payload bytes and
// Done/Error events; a negedge monitor pops and compares whenever the DUT emits them.
module tb_uart_rx_frame_parser;
   localparam int MAXL = 64;
   localparam int TMO  = 100;
   localparam logic [2:0] EV_DONE = 3'b000, EV_CSUM = 3'b101, EV_LEN = 3'b110, EV_TMO = 3'b111;

   typedef logic [7:0] bq_t[$];

   logic       CLK = 1'b0;
   logic       Areset = 1'b0;
   logic       Rx_FIFO_Empty;
   logic [7:0] Rx_Data;
   logic       Read_Enable;
   logic [7:0] Payload_Data;
   logic       Payload_Valid;
   logic       Payload_Ready = 1'b0;
   logic       Frame_Done, Frame_Error;
   logic [1:0] Error_Code;

   always #5 CLK = ~CLK;

   uart_rx_frame_parser #(.MAX_LEN(MAXL), .TIMEOUT_CYCLES(TMO)) dut (
      .CLK(CLK), .Areset(Areset), .Rx_FIFO_Empty(Rx_FIFO_Empty), .Rx_Data(Rx_Data),
      .Read_Enable(Read_Enable), .Payload_Data(Payload_Data), .Payload_Valid(Payload_Valid),
      .Payload_Ready(Payload_Ready), .Frame_Done(Frame_Done), .Frame_Error(Frame_Error),
      .Error_Code(Error_Code)
   );

   logic [7:0] fifo[$];
   logic [7:0] exp_pl[$];
   logic [2:0] exp_ev[$];
   int n_cmp = 0, n_bad = 0;
   int pop_empty = 0, re_back = 0, re_empty = 0, both = 0, n_pulse = 0;
   int rdy_mode = 1;
   logic re_prev = 1'b0;

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, got, exp);
      end
   endtask

   // Frame-level reference: walk the byte stream by the framing rules.
   task automatic model(input bq_t s);
      int i = 0;
      int len;
      logic [7:0] sum;
      while (i < s.size()) begin
         if (s[i] != 8'hA5) begin i++; continue; end
         i++;
         if (i >= s.size()) break;
         len = int'(s[i]); i++;
         if (len > MAXL) begin exp_ev.push_back(EV_LEN); continue; end
         sum = 8'(len);
         for (int k = 0; k < len && i < s.size(); k++) begin
            exp_pl.push_back(s[i]);
            sum = sum ^ s[i];
            i++;
         end
         if (i >= s.size()) break;
         exp_ev.push_back((s[i] == sum) ? EV_DONE : EV_CSUM);
         i++;
      end
   endtask

   // Rx FIFO model: data appears the cycle after Read_Enable.
   always @(posedge CLK or negedge Areset) begin
      if (!Areset) begin
         fifo.delete();
         Rx_Data       <= 8'h00;
         Rx_FIFO_Empty <= 1'b1;
      end else begin
         if (Read_Enable) begin
            if (fifo.size() == 0) pop_empty <= pop_empty + 1;
            else Rx_Data <= fifo.pop_front();
         end
         Rx_FIFO_Empty <= (fifo.size() == 0);
      end
   end

   initial begin
      forever begin
         @(posedge CLK);
         #1;
         case (rdy_mode)
            0:       Payload_Ready = ($urandom_range(0, 3) != 0);
            2:       Payload_Ready = 1'b0;
            default: Payload_Ready = 1'b1;
         endcase
      end
   end

   always @(negedge CLK) begin
      if (Areset) begin
         if (Read_Enable && re_prev) re_back++;
         if (Read_Enable && Rx_FIFO_Empty) re_empty++;
         re_prev = Read_Enable;
         if (Frame_Done && Frame_Error) both++;
         if (Payload_Valid && Payload_Ready) begin
            if (exp_pl.size() == 0) check("payload_extra", {24'h0, Payload_Data}, 32'hFFFF);
            else check("payload", {24'h0, Payload_Data}, {24'h0, exp_pl.pop_front()});
         end
         if (Frame_Done || Frame_Error) begin
            n_pulse++;
            if (exp_ev.size() == 0) check("event_extra", {29'h0, Frame_Error, Error_Code}, 32'hFFFF);
            else check("event", {29'h0, Frame_Error, Error_Code}, {29'h0, exp_ev.pop_front()});
         end
      end
   end

   task automatic feed(input bq_t s, input int maxgap);
      model(s);
      foreach (s[i]) begin
         repeat ($urandom_range(0, maxgap)) @(negedge CLK);
         fifo.push_back(s[i]);
      end
   endtask

   task automatic wait_idle(input string nm, input int budget);
      int t = 0;
      while ((fifo.size() != 0 || exp_pl.size() != 0 || exp_ev.size() != 0) && t < budget) begin
         @(negedge CLK);
         t++;
      end
      repeat (12) @(negedge CLK);
      check({"drain_", nm}, (t < budget), 1);
   endtask

   task automatic do_reset(input string nm);
      @(negedge CLK);
      Areset = 1'b0;
      @(negedge CLK);
      check({"rst_outs_", nm},
            {14'h0, Read_Enable, Payload_Valid, Frame_Done, Frame_Error, Error_Code, Payload_Data},
            32'h0);
      exp_pl.delete();
      exp_ev.delete();
      re_prev = 1'b0;
      @(negedge CLK);
      Areset = 1'b1;
   endtask

   initial begin
      bq_t s;
      int re_cnt, bad_data, t, p0;
      rdy_mode = 1;
      do_reset("init");

      // Empty FIFO: no pops at all.
      re_cnt = 0;
      repeat (50) begin @(negedge CLK); if (Read_Enable) re_cnt++; end
      check("empty_no_pop", re_cnt, 0);

      s = '{8'h33, 8'hA5, 8'h03, 8'h11, 8'h22, 8'h44, 8'h74};
      feed(s, 2);
      wait_idle("good3", 500);

      s = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
      feed(s, 0);
      wait_idle("badcsum", 500);

      s = '{8'hA5, 8'h41, 8'hA5, 8'h00, 8'h00};
      feed(s, 1);
      wait_idle("badlen_len0", 500);

      // Backpressure: first byte held, no pops during the stall.
      rdy_mode = 2;
      s = '{8'hA5, 8'h02, 8'hAA, 8'hBB, 8'h13};
      feed(s, 0);
      t = 0;
      while (!Payload_Valid && t < 200) begin @(negedge CLK); t++; end
      check("stall_valid_seen", (t < 200), 1);
      re_cnt = 0; bad_data = 0;
      repeat (20) begin
         @(negedge CLK);
         if (Read_Enable) re_cnt++;
         if (Payload_Data != 8'hAA || !Payload_Valid) bad_data++;
      end
      check("stall_no_pop", re_cnt, 0);
      check("stall_data_held", bad_data, 0);
      rdy_mode = 1;
      wait_idle("stall", 500);

      // Reset mid-frame: frame dropped, parser back in HUNT.
      s = '{8'hA5, 8'h04, 8'h11};
      feed(s, 0);
      wait_idle("partial", 500);
      do_reset("midframe");
      s = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
      feed(s, 0);
      wait_idle("after_rst", 500);

      // Stall on an incomplete frame.
      p0 = n_pulse;
      s = '{8'hA5, 8'h03, 8'h11};
      feed(s, 0);
`ifdef UART_PARSER_TIMEOUT_EN
      exp_ev.push_back(EV_TMO);
`endif
      repeat (1000) @(negedge CLK);
`ifdef UART_PARSER_TIMEOUT_EN
      check("timeout_pulses", n_pulse - p0, 1);
`else
      check("no_timeout_pulses", n_pulse - p0, 0);
`endif
      check("timeout_q_empty", exp_ev.size() + exp_pl.size(), 0);
      do_reset("post_timeout");

      // Randomized frames with random backpressure and FIFO gaps.
      rdy_mode = 0;
      s = {};
      for (int f = 0; f < 30; f++) begin
         int kind, len;
         logic [7:0] sum, b;
         repeat ($urandom_range(0, 2)) begin
            do b = 8'($urandom_range(0, 255)); while (b == 8'hA5);
            s.push_back(b);
         end
         kind = $urandom_range(0, 9);
         s.push_back(8'hA5);
         if (kind == 0) begin
            s.push_back(8'($urandom_range(MAXL + 1, 255)));
         end else begin
            len = (kind == 1) ? 0 : (kind == 2 ? MAXL : $urandom_range(1, 20));
            s.push_back(8'(len));
            sum = 8'(len);
            for (int k = 0; k < len; k++) begin
               b = 8'($urandom_range(0, 255));
               s.push_back(b);
               sum = sum ^ b;
            end
            s.push_back((kind == 3) ? (sum ^ 8'(1 << $urandom_range(0, 7))) : sum);
         end
      end
      feed(s, 3);
      wait_idle("random", 20000);
      rdy_mode = 1;
      repeat (10) @(negedge CLK);

      check("pop_on_empty", pop_empty, 0);
      check("re_back_to_back", re_back, 0);
      check("re_while_empty", re_empty, 0);
      check("done_and_error", both, 0);
      check("leftover_expect", exp_pl.size() + exp_ev.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
